cpu_mem_responder: RTL and testbench

Bus-side responder for the CPU core's memory request interface. It samples `req_rdwr`/`which_rdwr`/`addr`/`data_out` from the CPU and services each request against an internal synchronous RAM window. It inserts a configurable number of wait states, then returns read data on the CPU's `data_in` together with a one-cycle `ready` strobe. It sits between `Cpu` and the rest of the memory map as the default RAM target.

---
 rtl/cpu_mem_responder_pkg.sv | 45 ++++
 rtl/cpu_mem_responder_ram.sv | 31 +++
 rtl/cpu_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_responder_pkg.sv
// Shared constants for the CPU memory responder.
// Mirrors the CPU data/address width defines and the read/write and
// responder-state enumerations so every file of the block agrees on them.
package cpu_mem_responder_pkg;

    // CPU bus widths (byte data, 24-bit absolute byte address).
    localparam int CPU_DATA_MSB_POS     = 7;
    localparam int CPU_ABS_ADDR_MSB_POS = 23;

    // Direction of a CPU memory request.
    localparam logic ENUM__CPU_WH_RDWR__READ  = 1'b0;
    localparam logic ENUM__CPU_WH_RDWR__WRITE = 1'b1;

    // Responder state encoding; MSB position of the state vector.
    localparam int _ENUM_MP__CPU_MEM_RESP_STATE = 1;

    typedef logic [_ENUM_MP__CPU_MEM_RESP_STATE:0] resp_state_t;

    localparam resp_state_t ENUM__CPU_MEM_RESP_STATE__IDLE   = 2'd0;
    localparam resp_state_t ENUM__CPU_MEM_RESP_STATE__WAIT   = 2'd1;
    localparam resp_state_t ENUM__CPU_MEM_RESP_STATE__ACCESS = 2'd2;
    localparam resp_state_t ENUM__CPU_MEM_RESP_STATE__RESP   = 2'd3;

    // True when a window-relative offset lands inside a 2^depth_log2 byte
    // window. The offset is already wrapped to 24 bits, so addresses below
    // the base appear as huge offsets and never alias into the window.
    function automatic logic offset_in_window(
        input logic [CPU_ABS_ADDR_MSB_POS:0] offset,
        input int                            depth_log2
    );
        if (depth_log2 >= CPU_ABS_ADDR_MSB_POS + 1) begin
            return 1'b1;
        end
        return ((offset >> depth_log2) == '0);
    endfunction

    // Reload value for the wait counter: it counts WAIT_STATES-1 down to 0.
    function automatic logic [3:0] wait_load_value(input int wait_states);
        if (wait_states > 0) begin
            return 4'(wait_states - 1);
        end
        return 4'd0;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_ram.sv
// cpu_sp_ram: single-port synchronous byte RAM with registered read data.
// Read-first: a write cycle returns the old contents on rdata.
// The whole port is gated by en so rdata holds while the bus is stalled.
module cpu_sp_ram #(
    parameter int DEPTH_LOG2 = 16,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];
    logic [DATA_W-1:0] rdata_reg;

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: default RAM target on the CPU memory request bus.
// A request is latched in IDLE, optionally delayed by WAIT_STATES cycles,
// performed against the internal RAM window in ACCESS and acknowledged
// from RESP with a registered one-cycle ready (plus bus_err on rejects).
// Optional build macro CPU_MEM_RESP_WP_EN: writes to window offsets
// 0..WP_LIMIT are dropped and reported with bus_err.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter logic [CPU_ABS_ADDR_MSB_POS:0] BASE_ADDR   = 24'h000000,
    parameter int                            DEPTH_LOG2  = 16,
    parameter int                            WAIT_STATES = 0,
    parameter logic [15:0]                   WP_LIMIT    = 16'h0FFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          req_rdwr,
    input  logic                          which_rdwr,
    input  logic [CPU_ABS_ADDR_MSB_POS:0] addr,
    input  logic [CPU_DATA_MSB_POS:0]     wr_data,
    output logic [CPU_DATA_MSB_POS:0]     rd_data,
    output logic                          ready,
    output logic                          bus_err
);

    localparam logic [3:0] WAIT_LOAD = wait_load_value(WAIT_STATES);

    // FSM and wait counter
    resp_state_t state_reg;
    resp_state_t state_next;
    logic [3:0]  wait_cnt_reg;
    logic [3:0]  wait_cnt_next;

    // Request captured in IDLE; held stable for the rest of the access
    logic                          req_write_reg;
    logic                          req_in_range_reg;
    logic                          req_wp_reg;
    logic [DEPTH_LOG2-1:0]         req_addr_reg;
    logic [CPU_DATA_MSB_POS:0]     req_wdata_reg;

    // Output registers
    logic [CPU_DATA_MSB_POS:0]     rd_data_reg;
    logic                          ready_reg;
    logic                          bus_err_reg;

    // Live decode of the incoming address
    logic [CPU_ABS_ADDR_MSB_POS:0] offset;
    logic                          in_range_now;
    logic                          wp_hit_now;
    logic                          req_err;

    // RAM port
    logic                          ram_en;
    logic                          ram_we;
    logic [CPU_DATA_MSB_POS:0]     ram_rdata;

    logic in_idle;
    logic in_access;
    logic in_resp;
    logic take_req;

    assign in_idle   = (state_reg == ENUM__CPU_MEM_RESP_STATE__IDLE);
    assign in_access = (state_reg == ENUM__CPU_MEM_RESP_STATE__ACCESS);
    assign in_resp   = (state_reg == ENUM__CPU_MEM_RESP_STATE__RESP);
    assign take_req  = rst && enable && in_idle && req_rdwr;

    // Offset wraps modulo 2^24, so addresses below BASE_ADDR fall far outside.
    assign offset       = addr - BASE_ADDR;
    assign in_range_now = offset_in_window(offset, DEPTH_LOG2);

`ifdef CPU_MEM_RESP_WP_EN
    assign wp_hit_now = (which_rdwr == ENUM__CPU_WH_RDWR__WRITE) && in_range_now
                        && (offset <= {8'h00, WP_LIMIT});
`else
    assign wp_hit_now = 1'b0;
`endif

    assign req_err = !req_in_range_reg || req_wp_reg;

    // Next-state and wait counter logic
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ENUM__CPU_MEM_RESP_STATE__IDLE: begin
                if (req_rdwr) begin
                    if (WAIT_STATES > 0) begin
                        state_next    = ENUM__CPU_MEM_RESP_STATE__WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = ENUM__CPU_MEM_RESP_STATE__ACCESS;
                    end
                end
            end
            ENUM__CPU_MEM_RESP_STATE__WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = ENUM__CPU_MEM_RESP_STATE__ACCESS;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ENUM__CPU_MEM_RESP_STATE__ACCESS: begin
                state_next = ENUM__CPU_MEM_RESP_STATE__RESP;
            end
            default: begin
                // RESP: request line is ignored here, always return to IDLE
                state_next = ENUM__CPU_MEM_RESP_STATE__IDLE;
            end
        endcase
    end

    // State register: reset wins over enable, disabled cycles hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ENUM__CPU_MEM_RESP_STATE__IDLE;
            wait_cnt_reg <= 4'd0;
        end else if (enable) begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Capture the request; later input changes cannot disturb the access
    always_ff @(posedge clk) begin
        if (take_req) begin
            req_write_reg    <= (which_rdwr == ENUM__CPU_WH_RDWR__WRITE);
            req_in_range_reg <= in_range_now;
            req_wp_reg       <= wp_hit_now;
            req_addr_reg     <= offset[DEPTH_LOG2-1:0];
            req_wdata_reg    <= wr_data;
        end
    end

    // The RAM only sees a write on an enabled, non-reset ACCESS edge, so a
    // reset anywhere before that edge drops the write.
    assign ram_en = rst && enable;
    assign ram_we = ram_en && in_access && req_write_reg && !req_err;

    cpu_sp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (CPU_DATA_MSB_POS + 1)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (req_addr_reg),
        .wdata (req_wdata_reg),
        .rdata (ram_rdata)
    );

    // Response registers: updated on the RESP edge, one-cycle strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_reg <= '0;
            ready_reg   <= 1'b0;
            bus_err_reg <= 1'b0;
        end else if (enable) begin
            ready_reg   <= in_resp;
            bus_err_reg <= in_resp && req_err;
            if (in_resp && !req_write_reg) begin
                rd_data_reg <= req_in_range_reg ? ram_rdata : 8'hFF;
            end
        end
    end

    assign rd_data = rd_data_reg;
    assign ready   = ready_reg;
    assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
`timescale 1ns/1ps
// Scoreboard bench: two responders (0 and 3 wait states) share clock,
// reset and enable. The driver predicts each response from a byte-map
// model and queues it; a negedge monitor pops and compares on every ready.
module tb_cpu_mem_responder;
    import cpu_mem_responder_pkg::*;

    localparam int NDUT  = 2;
    localparam int DEPTH = 16;
    localparam int NPOOL = 12;

    typedef struct {
        int         dut;
        int         cyc;
        logic [7:0] rd;
        logic       err;
        bit         rd_chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       enable;
    logic       req   [NDUT];
    logic       which [NDUT];
    logic [23:0] addr [NDUT];
    logic [7:0] wd    [NDUT];
    logic [7:0] rd    [NDUT];
    logic       ready [NDUT];
    logic       berr  [NDUT];

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            cpu_mem_responder #(
                .BASE_ADDR   (24'h000000),
                .DEPTH_LOG2  (DEPTH),
                .WAIT_STATES (gi * 3),
                .WP_LIMIT    (16'h0FFF)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .enable     (enable),
                .req_rdwr   (req[gi]),
                .which_rdwr (which[gi]),
                .addr       (addr[gi]),
                .wr_data    (wd[gi]),
                .rd_data    (rd[gi]),
                .ready      (ready[gi]),
                .bus_err    (berr[gi])
            );
        end
    endgenerate

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference state: bytes written per DUT, last read value per DUT
    logic [7:0] mem_model [int];
    logic [7:0] last_rd    [NDUT];
    bit         last_known [NDUT];

    logic [23:0] pool [NPOOL] = '{24'h000000, 24'h000001, 24'h000010, 24'h000123,
                                  24'h000800, 24'h000FFF, 24'h001000, 24'h00ABCD,
                                  24'h00FFFF, 24'h010000, 24'h7FFFFF, 24'hFFFFFF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic clear_last();
        for (int i = 0; i < NDUT; i++) begin
            last_rd[i]    = 8'h00;
            last_known[i] = 1'b1;
        end
    endtask

    // Expected response from the access rules: window hit test, optional
    // write protection, read-old-value on writes, FF on missed reads.
    task automatic model(input int d, input bit wr, input logic [23:0] a,
                         input logic [7:0] wdv, output exp_t e);
        logic [23:0] off;
        int key;
        bit prot;
        off  = a - 24'h000000;
        key  = (d << 24) | int'(off);
        prot = 1'b0;
`ifdef CPU_MEM_RESP_WP_EN
        prot = wr && (int'(off) <= 32'h0FFF);
`endif
        e.dut = d;
        e.cyc = 0;
        if (int'(off) >= (1 << DEPTH)) begin
            e.err = 1'b1;
            if (wr) begin
                e.rd = last_rd[d]; e.rd_chk = last_known[d];
            end else begin
                e.rd = 8'hFF; e.rd_chk = 1'b1;
            end
        end else if (wr) begin
            e.err = prot;
            e.rd = last_rd[d]; e.rd_chk = last_known[d];
            if (!prot) mem_model[key] = wdv;
        end else begin
            e.err = 1'b0;
            e.rd_chk = mem_model.exists(key);
            e.rd = e.rd_chk ? mem_model[key] : 8'h00;
        end
        last_rd[d]    = e.rd;
        last_known[d] = e.rd_chk;
    endtask

    // One access on DUT d; enable is dropped for st_len edges after st_at
    // enabled edges (st_at never beyond the completing edge).
    task automatic access(input int d, input bit wr, input logic [23:0] a,
                          input logic [7:0] wdv, input int st_at, input int st_len);
        exp_t e;
        int n;
        model(d, wr, a, wdv, e);
        enable   = 1'b1;
        req[d]   = 1'b1;
        which[d] = wr ? ENUM__CPU_WH_RDWR__WRITE : ENUM__CPU_WH_RDWR__READ;
        addr[d]  = a;
        wd[d]    = wdv;
        @(posedge clk); #1;
        e.cyc = cyc + d * 3 + 2 + st_len;
        exp_q.push_back(e);
        req[d]   = 1'b0;
        which[d] = 1'($urandom);
        addr[d]  = 24'($urandom);
        wd[d]    = 8'($urandom);
        if (st_len > 0) begin
            for (int k = 0; k < st_at; k++) begin @(posedge clk); #1; end
            enable = 1'b0;
            for (int k = 0; k < st_len; k++) begin @(posedge clk); #1; end
            enable = 1'b1;
        end
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL timeout: dut%0d addr %06h got no ready, expected ready at cycle %0d",
                     d, a, e.cyc);
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            chk({tag, "_ready"},   32'(ready[i]), 32'h0);
            chk({tag, "_bus_err"}, 32'(berr[i]),  32'h0);
            chk({tag, "_rd_data"}, 32'(rd[i]),    32'h0);
        end
    endtask

    // Monitor: every ready must match the oldest outstanding expectation
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (ready[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_ready: dut%0d ready=1 at cycle %0d, expected none", i, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_dut", 32'(i), 32'(mon_e.dut));
                    chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.rd_chk) chk("rd_data", 32'(rd[i]), 32'(mon_e.rd));
                    chk("bus_err", 32'(berr[i]), 32'(mon_e.err));
                    $display("txn dut%0d cycle %0d rd_data %02h bus_err %0d", i, cyc, rd[i], berr[i]);
                end
            end else if (berr[i] !== 1'b0) begin
                n_vec++; n_err++;
                $display("FAIL lone_bus_err: dut%0d bus_err=%b without ready, expected 0", i, berr[i]);
            end
        end
    end

    initial begin
        int d;
        rst = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            req[i] = 1'b0; which[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        clear_last();
        repeat (3) begin @(posedge clk); #1; end
        chk_reset_outputs("por");
        rst = 1'b1;

        // Fill every in-window pool location on both DUTs
        for (int j = 0; j < NPOOL; j++)
            for (int i = 0; i < NDUT; i++)
                access(i, 1'b1, pool[j], 8'($urandom), 0, 0);

        // Write then read back, zero wait states
        access(0, 1'b1, 24'h000123, 8'hA5, 0, 0);
        access(0, 1'b0, 24'h000123, 8'h00, 0, 0);
        access(1, 1'b1, 24'h000123, 8'hA5, 0, 0);

        // Three wait states: plain read, then the same read stalled in WAIT
        access(1, 1'b0, 24'h000123, 8'h00, 0, 0);
        access(1, 1'b0, 24'h000123, 8'h00, 1, 2);

        // Out-of-window read and write, then the window base is untouched
        for (int i = 0; i < NDUT; i++) begin
            access(i, 1'b0, 24'h010000, 8'h00, 0, 0);
            access(i, 1'b1, 24'h010000, 8'h5A, 0, 0);
            access(i, 1'b0, 24'h000000, 8'h00, 0, 0);
        end

        // Reset held with a write request pending: nothing may happen
        for (int i = 0; i < NDUT; i++) begin
            req[i] = 1'b1; which[i] = ENUM__CPU_WH_RDWR__WRITE;
            addr[i] = 24'h000010; wd[i] = 8'h99;
        end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk_reset_outputs("rst_req");
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) req[i] = 1'b0;
        clear_last();
        for (int i = 0; i < NDUT; i++) access(i, 1'b0, 24'h000010, 8'h00, 0, 0);

        // Reset during WAIT of a write: the write must be lost
        req[1] = 1'b1; which[1] = ENUM__CPU_WH_RDWR__WRITE;
        addr[1] = 24'h000010; wd[1] = 8'h77;
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk_reset_outputs("rst_wait");
        clear_last();
        repeat (6) begin @(posedge clk); #1; end
        access(1, 1'b0, 24'h000010, 8'h00, 0, 0);

        // Write-protect boundary
        for (int i = 0; i < NDUT; i++) begin
            access(i, 1'b1, 24'h000800, 8'h3C, 0, 0);
            access(i, 1'b1, 24'h001000, 8'hC3, 0, 0);
            access(i, 1'b0, 24'h000800, 8'h00, 0, 0);
            access(i, 1'b0, 24'h001000, 8'h00, 0, 0);
        end

        // Random back-to-back traffic with occasional stalls
        repeat (160) begin
            int st_len;
            d = int'($urandom_range(0, NDUT - 1));
            st_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            access(d, 1'($urandom), pool[$urandom_range(0, NPOOL - 1)], 8'($urandom),
                   int'($urandom_range(0, d * 3 + 1)), st_len);
        end

        repeat (4) begin @(posedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
